// File: rtl/datapath_controller.sv
// Multi-cycle MIPS-subset controller: IDLE/DECODE/EXEC/MEM/WB sequencing of datapath control lines.
// Optional CTRL_INSTR_COUNT_EN adds o_instr_count, a wrapping count of retired legal instructions.
module datapath_controller (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_instr,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_illegal,
  output logic [4:0]  o_first5bits,
  output logic [4:0]  o_second5bits,
  output logic [15:0] o_immediate,
  output logic        o_regDst,
  output logic        o_ReadWriteRF,
  output logic        o_RFSource,
  output logic        o_AluSource,
  output logic [2:0]  o_AluControl,
  output logic        o_WriteEnDataMemory,
  output logic        o_ReadEnDataMemory,
`ifdef CTRL_INSTR_COUNT_EN
  output logic [31:0] o_instr_count,
`endif
  output logic        o_MemToReg
);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;

  state_t      r_state;
  logic        r_done, r_illegal, r_regdst, r_rfwe, r_alusrc, r_memwe, r_memre, r_memtoreg;
  logic        r_is_lw, r_is_sw;
  logic [2:0]  r_aluctl;
  logic [4:0]  r_rs, r_rt;
  logic [15:0] r_imm;

  logic [5:0]  w_op, w_funct;
  logic        w_legal, w_is_r, w_is_imm, w_is_lw, w_is_sw;
  logic [2:0]  w_alu;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];

  always_comb begin
    w_legal  = 1'b0;
    w_is_r   = 1'b0;
    w_is_imm = 1'b0;
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    w_alu    = 3'b000;
    case (w_op)
      6'h00: begin
        w_legal = 1'b1;
        w_is_r  = 1'b1;
        case (w_funct)
          6'h20:   w_alu = 3'b010;
          6'h22:   w_alu = 3'b110;
          6'h24:   w_alu = 3'b000;
          6'h25:   w_alu = 3'b001;
          6'h2A:   w_alu = 3'b111;
          default: begin
            w_legal = 1'b0;
            w_is_r  = 1'b0;
          end
        endcase
      end
      6'h08: begin w_legal = 1'b1; w_is_imm = 1'b1; w_alu = 3'b010; end
      6'h23: begin w_legal = 1'b1; w_is_imm = 1'b1; w_is_lw = 1'b1; w_alu = 3'b010; end
      6'h2B: begin w_legal = 1'b1; w_is_imm = 1'b1; w_is_sw = 1'b1; w_alu = 3'b010; end
      default: ;
    endcase
  end

  // Outputs are registered for the state being entered; r_done marks the final cycle,
  // so the next edge always returns to IDLE with every control line cleared.
  always_ff @(posedge i_clk) begin
    if (i_rst || r_done) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_illegal  <= 1'b0;
      r_regdst   <= 1'b0;
      r_rfwe     <= 1'b0;
      r_alusrc   <= 1'b0;
      r_aluctl   <= 3'b000;
      r_memwe    <= 1'b0;
      r_memre    <= 1'b0;
      r_memtoreg <= 1'b0;
      r_is_lw    <= 1'b0;
      r_is_sw    <= 1'b0;
      r_rs       <= 5'd0;
      r_rt       <= 5'd0;
      r_imm      <= 16'd0;
    end else begin
      r_rfwe  <= 1'b0;
      r_memwe <= 1'b0;
      r_memre <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_DECODE;
            r_rs       <= i_instr[25:21];
            r_rt       <= i_instr[20:16];
            r_imm      <= i_instr[15:0];
            r_regdst   <= w_is_r;
            r_alusrc   <= w_is_imm;
            r_aluctl   <= w_alu;
            r_memtoreg <= w_is_lw;
            r_is_lw    <= w_is_lw;
            r_is_sw    <= w_is_sw;
            r_done     <= ~w_legal;
            r_illegal  <= ~w_legal;
          end
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (r_is_lw || r_is_sw) begin
            r_state <= S_MEM;
            r_memre <= r_is_lw;
            r_memwe <= r_is_sw;
            r_done  <= r_is_sw;
          end else begin
            r_state <= S_WB;
            r_rfwe  <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        S_MEM: begin
          r_state <= S_WB;
          r_rfwe  <= 1'b1;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Reset masks every output in the same cycle so an aborted instruction never shows an enable or done.
  assign o_busy              = (r_state != S_IDLE) & ~i_rst;
  assign o_done              = r_done & ~i_rst;
  assign o_illegal           = r_illegal & ~i_rst;
  assign o_first5bits        = r_rs & {5{~i_rst}};
  assign o_second5bits       = r_rt & {5{~i_rst}};
  assign o_immediate         = r_imm & {16{~i_rst}};
  assign o_regDst            = r_regdst & ~i_rst;
  assign o_ReadWriteRF       = r_rfwe & ~i_rst;
  assign o_RFSource          = 1'b0;
  assign o_AluSource         = r_alusrc & ~i_rst;
  assign o_AluControl        = r_aluctl & {3{~i_rst}};
  assign o_WriteEnDataMemory = r_memwe & ~i_rst;
  assign o_ReadEnDataMemory  = r_memre & ~i_rst;
  assign o_MemToReg          = r_memtoreg & ~i_rst;

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] r_instr_count;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_instr_count <= 32'd0;
    else if (r_done && !r_illegal)
      r_instr_count <= r_instr_count + 32'd1;
  end

  assign o_instr_count = r_instr_count & {32{~i_rst}};
`endif

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: per-cycle control vectors for add/sub/addi/lw/sw/illegal,
// start-while-busy and reset-mid-instruction.
module tb_datapath_controller;

  logic        i_clk = 1'b0;
  logic        i_rst, i_start;
  logic [31:0] i_instr;
  logic        o_busy, o_done, o_illegal, o_regDst, o_ReadWriteRF, o_RFSource, o_AluSource;
  logic        o_WriteEnDataMemory, o_ReadEnDataMemory, o_MemToReg;
  logic [4:0]  o_first5bits, o_second5bits;
  logic [15:0] o_immediate;
  logic [2:0]  o_AluControl;
`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] o_instr_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  datapath_controller dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instr(i_instr),
    .o_busy(o_busy), .o_done(o_done), .o_illegal(o_illegal),
    .o_first5bits(o_first5bits), .o_second5bits(o_second5bits), .o_immediate(o_immediate),
    .o_regDst(o_regDst), .o_ReadWriteRF(o_ReadWriteRF), .o_RFSource(o_RFSource),
    .o_AluSource(o_AluSource), .o_AluControl(o_AluControl),
    .o_WriteEnDataMemory(o_WriteEnDataMemory), .o_ReadEnDataMemory(o_ReadEnDataMemory),
`ifdef CTRL_INSTR_COUNT_EN
    .o_instr_count(o_instr_count),
`endif
    .o_MemToReg(o_MemToReg)
  );

  // {busy,done,illegal,regDst,ReadWriteRF,RFSource,AluSource,AluControl[2:0],WrMem,RdMem,MemToReg}
  logic [12:0] ctl;
  logic [25:0] fld;
  assign ctl = {o_busy, o_done, o_illegal, o_regDst, o_ReadWriteRF, o_RFSource, o_AluSource,
                o_AluControl, o_WriteEnDataMemory, o_ReadEnDataMemory, o_MemToReg};
  assign fld = {o_first5bits, o_second5bits, o_immediate};

  localparam logic [12:0] C_IDLE   = 13'b0_0_0_0_0_0_0_000_0_0_0;
  localparam logic [12:0] C_ADD_DX = 13'b1_0_0_1_0_0_0_010_0_0_0;
  localparam logic [12:0] C_ADD_WB = 13'b1_1_0_1_1_0_0_010_0_0_0;
  localparam logic [12:0] C_SUB_DX = 13'b1_0_0_1_0_0_0_110_0_0_0;
  localparam logic [12:0] C_SUB_WB = 13'b1_1_0_1_1_0_0_110_0_0_0;
  localparam logic [12:0] C_ADI_DX = 13'b1_0_0_0_0_0_1_010_0_0_0;
  localparam logic [12:0] C_ADI_WB = 13'b1_1_0_0_1_0_1_010_0_0_0;
  localparam logic [12:0] C_LW_DX  = 13'b1_0_0_0_0_0_1_010_0_0_1;
  localparam logic [12:0] C_LW_MEM = 13'b1_0_0_0_0_0_1_010_0_1_1;
  localparam logic [12:0] C_LW_WB  = 13'b1_1_0_0_1_0_1_010_0_0_1;
  localparam logic [12:0] C_SW_DX  = 13'b1_0_0_0_0_0_1_010_0_0_0;
  localparam logic [12:0] C_SW_MEM = 13'b1_1_0_0_0_0_1_010_1_0_0;
  localparam logic [12:0] C_ILL    = 13'b1_1_1_0_0_0_0_000_0_0_0;

  localparam logic [31:0] I_ADD  = 32'h0043_0820;  // add r1, r2, r3
  localparam logic [31:0] I_SUB  = 32'h00A6_2022;  // sub r4, r5, r6
  localparam logic [31:0] I_NOR  = 32'h00A6_2027;  // R-type with undecoded funct
  localparam logic [31:0] I_ADDI = 32'h20A6_0007;  // addi r6, r5, 7
  localparam logic [31:0] I_LW   = 32'h8C41_0004;
  localparam logic [31:0] I_SW   = 32'hAC41_0004;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  // Presents an instruction at a negedge; it is accepted on the following rising edge
  // and the call returns at the negedge of cycle 1 (DECODE) with i_start dropped.
  task automatic issue(input logic [31:0] instr);
    i_start = 1'b1;
    i_instr = instr;
    cyc();
    i_start = 1'b0;
  endtask

`ifdef CTRL_INSTR_COUNT_EN
  logic [31:0] exp_cnt = 32'd0;
`endif

  initial begin
    i_rst = 1'b1; i_start = 1'b1; i_instr = I_ADD;
    cyc(); cyc();
    chk("reset_ctl_with_start", {19'd0, ctl}, {19'd0, C_IDLE});
    chk("reset_fields", {6'd0, fld}, 32'd0);
    i_start = 1'b0;
    i_rst = 1'b0;
    cyc();
    chk("idle_after_reset", {19'd0, ctl}, {19'd0, C_IDLE});
`ifdef CTRL_INSTR_COUNT_EN
    chk("count_reset", o_instr_count, 32'd0);
`endif

    // add: DECODE, EXEC, WB(done at cycle 3), then IDLE
    issue(I_ADD);
    chk("add_c1_ctl", {19'd0, ctl}, {19'd0, C_ADD_DX});
    cyc();
    chk("add_exec_ctl", {19'd0, ctl}, {19'd0, C_ADD_DX});
    chk("add_exec_fields", {6'd0, fld}, {6'd0, 5'd2, 5'd3, 16'h0820});
    cyc();
    chk("add_wb_ctl", {19'd0, ctl}, {19'd0, C_ADD_WB});
    cyc();
    chk("add_idle_ctl", {19'd0, ctl}, {19'd0, C_IDLE});
    chk("add_idle_fields", {6'd0, fld}, 32'd0);
`ifdef CTRL_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 32'd1;
    chk("count_after_add", o_instr_count, exp_cnt);
`endif

    // sub
    issue(I_SUB);
    cyc();
    chk("sub_exec_ctl", {19'd0, ctl}, {19'd0, C_SUB_DX});
    chk("sub_exec_fields", {6'd0, fld}, {6'd0, 5'd5, 5'd6, 16'h2022});
    cyc();
    chk("sub_wb_ctl", {19'd0, ctl}, {19'd0, C_SUB_WB});
    cyc();

    // addi
    issue(I_ADDI);
    chk("addi_dec_ctl", {19'd0, ctl}, {19'd0, C_ADI_DX});
    cyc();
    cyc();
    chk("addi_wb_ctl", {19'd0, ctl}, {19'd0, C_ADI_WB});
    cyc();

    // lw: DECODE, EXEC, MEM, WB(done at cycle 4)
    issue(I_LW);
    chk("lw_dec_ctl", {19'd0, ctl}, {19'd0, C_LW_DX});
    cyc();
    chk("lw_exec_ctl", {19'd0, ctl}, {19'd0, C_LW_DX});
    cyc();
    chk("lw_mem_ctl", {19'd0, ctl}, {19'd0, C_LW_MEM});
    cyc();
    chk("lw_wb_ctl", {19'd0, ctl}, {19'd0, C_LW_WB});
    chk("lw_wb_fields", {6'd0, fld}, {6'd0, 5'd2, 5'd1, 16'h0004});
    cyc();
    chk("lw_idle_ctl", {19'd0, ctl}, {19'd0, C_IDLE});

    // sw: DECODE, EXEC, MEM(done at cycle 3)
    issue(I_SW);
    chk("sw_dec_ctl", {19'd0, ctl}, {19'd0, C_SW_DX});
    cyc();
    chk("sw_exec_ctl", {19'd0, ctl}, {19'd0, C_SW_DX});
    cyc();
    chk("sw_mem_ctl", {19'd0, ctl}, {19'd0, C_SW_MEM});
    cyc();
    chk("sw_idle_ctl", {19'd0, ctl}, {19'd0, C_IDLE});
`ifdef CTRL_INSTR_COUNT_EN
    exp_cnt = exp_cnt + 32'd4;
    chk("count_after_sw", o_instr_count, exp_cnt);
`endif

    // illegal opcode and illegal funct: done+illegal in DECODE, back to IDLE
    issue(I_BAD);
    chk("bad_op_ctl", {19'd0, ctl}, {19'd0, C_ILL});
    cyc();
    chk("bad_op_idle", {19'd0, ctl}, {19'd0, C_IDLE});
    issue(I_NOR);
    chk("bad_funct_ctl", {19'd0, ctl}, {19'd0, C_ILL});
    cyc();
    chk("bad_funct_idle", {19'd0, ctl}, {19'd0, C_IDLE});
`ifdef CTRL_INSTR_COUNT_EN
    chk("count_after_illegal", o_instr_count, exp_cnt);
`endif

    // start held across a lw; instr switched to add while busy must not be latched
    i_start = 1'b1;
    i_instr = I_LW;
    cyc();
    chk("busy_lw_c1", {19'd0, ctl}, {19'd0, C_LW_DX});
    i_instr = I_ADD;
    cyc();
    chk("busy_lw_c2_fields", {6'd0, fld}, {6'd0, 5'd2, 5'd1, 16'h0004});
    cyc();
    chk("busy_lw_c3", {19'd0, ctl}, {19'd0, C_LW_MEM});
    cyc();
    chk("busy_lw_c4", {19'd0, ctl}, {19'd0, C_LW_WB});
    cyc();
    chk("busy_idle_gap", {19'd0, ctl}, {19'd0, C_IDLE});
    cyc();
    i_start = 1'b0;
    chk("busy_second_accept", {19'd0, ctl}, {19'd0, C_ADD_DX});
    chk("busy_second_fields", {6'd0, fld}, {6'd0, 5'd2, 5'd3, 16'h0820});
    cyc();
    cyc();
    chk("busy_second_wb", {19'd0, ctl}, {19'd0, C_ADD_WB});
    cyc();

    // reset raised during MEM of sw
    issue(I_SW);
    cyc();
    cyc();
    chk("rst_pre_mem", {19'd0, ctl}, {19'd0, C_SW_MEM});
    i_rst = 1'b1;
    #1;
    chk("rst_in_mem_ctl", {19'd0, ctl}, {19'd0, C_IDLE});
    chk("rst_in_mem_fields", {6'd0, fld}, 32'd0);
    cyc();
    chk("rst_after_edge", {19'd0, ctl}, {19'd0, C_IDLE});
    i_rst = 1'b0;
    cyc();
    chk("rst_released_idle", {19'd0, ctl}, {19'd0, C_IDLE});
`ifdef CTRL_INSTR_COUNT_EN
    chk("count_after_reset", o_instr_count, 32'd0);
`endif
    issue(I_ADDI);
    chk("post_rst_accept", {19'd0, ctl}, {19'd0, C_ADI_DX});
    cyc();
    cyc();
    chk("post_rst_wb", {19'd0, ctl}, {19'd0, C_ADI_WB});
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
DATAPATH_CONTROLLER -- requirements
Module: datapath_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset. Reset is sampled only on the rising edge of i_clk.
REQ-002 SHALL provide: i_clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL provide: i_rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide: i_start  input  1  instruction request; accepted only in IDLE.
REQ-005 SHALL provide: i_instr  input  32  MIPS-format instruction; latched on accept.
REQ-006 SHALL provide: o_busy  output  1  high in every non-IDLE state.
REQ-007 SHALL provide: o_done  output  1  one-cycle pulse in the final cycle of each instruction.
REQ-008 SHALL provide: o_illegal  output  1  one-cycle pulse, coincident with o_done, for an undecoded instruction.
REQ-009 SHALL provide: o_first5bits  output  5  rs field (instr[25:21]).
REQ-010 SHALL provide: o_second5bits  output  5  rt field (instr[20:16]).
REQ-011 SHALL provide: o_immediate  output  16  instr[15:0]; carries rd in bits 15:11.
REQ-012 SHALL provide: o_regDst  output  1  1 selects rd, 0 selects rt as write register.
REQ-013 SHALL provide: o_ReadWriteRF  output  1  register file write enable.
REQ-014 SHALL provide: o_RFSource  output  1  register file data source; 0 selects the internal result.
REQ-015 SHALL provide: o_AluSource  output  1  1 selects the sign-extended immediate as ALU operand B.
REQ-016 SHALL provide: o_AluControl  output  3  ALU operation select.
REQ-017 SHALL provide: o_WriteEnDataMemory  output  1  data memory write enable.
REQ-018 SHALL provide: o_ReadEnDataMemory  output  1  data memory read enable.
REQ-019 SHALL provide: o_MemToReg  output  1  1 selects the data memory output as write-back data.

Function
REQ-020 SHALL implement registered states IDLE, DECODE, EXEC, MEM and WB.
REQ-021 SHALL, in IDLE with i_start=1, latch i_instr and enter DECODE on the next cycle; i_start is ignored in every other state.
REQ-022 SHALL decode the following opcodes:
- 0x00 R-type, by funct: 0x20 add=010, 0x22 sub=110, 0x24 and=000, 0x25 or=001, 0x2A slt=111.
- 0x08 addi.
- 0x23 lw.
- 0x2B sw.
- addi, lw and sw use AluControl=010.
REQ-023 SHALL sequence each instruction as follows:
- R-type and addi: DECODE->EXEC->WB->IDLE.
- lw: DECODE->EXEC->MEM->WB->IDLE.
- sw: DECODE->EXEC->MEM->IDLE.
REQ-024 SHALL give a latency from the accept edge to o_done of 3 cycles for R-type/addi, 4 for lw and 3 for sw.
REQ-025 SHALL hold o_first5bits, o_second5bits, o_immediate, o_regDst, o_AluSource, o_AluControl and o_MemToReg constant from DECODE through the final state, and drive them to 0 in IDLE.
REQ-026 SHALL set o_regDst=1 only for R-type, o_AluSource=1 for addi/lw/sw, and o_MemToReg=1 only for lw.
REQ-027 SHALL assert o_ReadWriteRF only in WB, o_ReadEnDataMemory only in MEM for lw, and o_WriteEnDataMemory only in MEM for sw.
REQ-028 SHALL drive o_RFSource=0 at all times.
REQ-029 SHALL assert o_done in WB, or in MEM for sw; the controller is back in IDLE on the next cycle and can accept a new i_start in that cycle.
REQ-030 SHALL handle an unknown opcode or unknown R-type funct as follows: DECODE->IDLE, with o_done=o_illegal=1 in DECODE and no enable asserted.
REQ-031 SHALL never assert o_ReadWriteRF and o_WriteEnDataMemory in the same cycle.

Reset
REQ-032 SHALL, while i_rst=1, force the state to IDLE and drive every output to 0.
REQ-033 SHALL let i_rst take priority over i_start.
REQ-034 SHALL, on reset mid-instruction, abort the instruction with no write enable asserted from the reset edge onward and no o_done for the aborted instruction.

Configuration
REQ-035 SHALL, with CTRL_INSTR_COUNT_EN defined, add the output o_instr_count (32 bits) with this behaviour:
- Reset value is 0.
- Increments by 1 in the cycle after each o_done with o_illegal=0.
- Wraps from 0xFFFFFFFF to 0.
REQ-036 SHALL, without CTRL_INSTR_COUNT_EN, omit the o_instr_count port and its counter logic entirely; all other behaviour is identical.

Verification
REQ-037 SHALL cover R-type add: i_instr=0x00430820 (add rd=1, rs=2, rt=3) -> in EXEC: regDst=1, AluControl=010, first5bits=2, second5bits=3; in WB: ReadWriteRF=1 with o_done=1, 3 cycles after accept.
REQ-038 SHALL cover lw: i_instr=0x8C410004 -> MEM: ReadEnDataMemory=1; WB: MemToReg=1, ReadWriteRF=1, regDst=0, AluSource=1, o_done=1 at cycle 4.
REQ-039 SHALL cover sw: i_instr=0xAC410004 -> MEM: WriteEnDataMemory=1 with o_done=1 at cycle 3; ReadWriteRF=0 throughout.
REQ-040 SHALL cover illegal: i_instr=0xFC000000 -> o_done=o_illegal=1 at cycle 1, no enable asserted; with the macro defined, o_instr_count is unchanged.
REQ-041 SHALL cover start while busy: i_start=1 held during a lw -> only one instruction executes; the second is accepted in the IDLE cycle after o_done.
REQ-042 SHALL cover reset mid-operation: i_rst=1 during the MEM state of sw -> WriteEnDataMemory=0 from that edge onward, all outputs 0, state IDLE, no o_done.
